siso_hd8: RTL and testbench
===========================

// Module: siso_hd8
// PURPOSE
//  High-density serial-in/serial-out delay line for the HDSISO8 tile.
//  - Consumes the resynchronised SISO_in bit from the input soup.
//  - Drives D_OUT, Johnson[3:0] and PULSES[7:0] to the pads.
//  - Storage is split into 8 lanes, selected round-robin by a 4-bit Johnson phase counter.
//  - Only one lane shifts per step, so each lane moves once every 8 steps.
// PARAMETERS
//  LANE_DEPTH  4  bits per lane; total delay = 8*LANE_DEPTH enabled steps (min 1)
// PORTS
//  CLK      in   1  single clock (CLK_OUT of the tile); all state on posedge
//  RESET    in   1  synchronous, active-high; priority over all other inputs
//  EN       in   1  step enable; 0 = every register holds
//  D_IN     in   1  serial data in
//  D_OUT    out  1  serial data out, registered
//  JOHNSON  out  4  Johnson phase counter state
//  PULSES   out  8  one-hot phase decode of JOHNSON, registered
//  VALID    out  1  1 once the line is primed (D_OUT carries data that was on D_IN)
// BEHAVIOUR
//  Reset values (RESET=1 at posedge, EN ignored):
//   - JOHNSON=4'b0000, PULSES=8'b00000001
//   - all lane bits=0, D_OUT=0, VALID=0, fill counter=0
//  Johnson sequence, phase k = 0..7, advances only when EN=1:
//   0000>0001>0011>0111>1111>1110>1100>1000>0000
//   next = {J[2:0], ~J[3]}
//  PULSES[k]=1 exactly when JOHNSON is in phase k.
//   - Registered together with JOHNSON; no extra latency.
//  Step (posedge with EN=1, RESET=0) in phase k:
//   - lane k shifts: lane[k][0]<=D_IN, lane[k][i]<=lane[k][i-1]
//   - D_OUT<=lane[k][LANE_DEPTH-1] (the bit being shifted out)
//   - other lanes hold; JOHNSON/PULSES advance to phase k+1 mod 8
//  Latency: bit sampled at step n appears on D_OUT after step n+8*LANE_DEPTH.
//   - Exact, counted in enabled steps; EN=0 cycles stretch it, data not lost.
//  Fill counter: width $clog2(8*LANE_DEPTH+1).
//   - +1 per step, saturates at 8*LANE_DEPTH.
//   - VALID=1 from the step at which it reaches 8*LANE_DEPTH.
//  Illegal Johnson codes (the 8 codes outside the sequence, upset only):
//   - next posedge forces JOHNSON=0000, PULSES=00000001, regardless of EN
//   - lanes/D_OUT hold; fill counter cleared; VALID=0
//  Reset mid-stream: all stored bits discarded, no partial output; refill from phase 0.
//  EN toggling every cycle: behaviour identical to continuous EN, only slower.
// CONFIGURATION
//  SISO_HD8_LOOP_EN defined:
//   - adds port LOOP (in, 1)
//   - when LOOP=1 the lane input is the bit shifted out of the same lane,
//     so the line recirculates its 8*LANE_DEPTH-bit pattern
//   - D_OUT and the fill counter behave as normal; D_IN ignored while LOOP=1
//  SISO_HD8_LOOP_EN undefined: no LOOP port; lane input is always D_IN.
// TESTING
//  1 Reset: RESET=1 for 1 edge mid-run -> JOHNSON=0000, PULSES=01, D_OUT=0, VALID=0.
//  2 Phase walk: EN=1 for 9 steps -> JOHNSON walks 0001..1000,0000, then 0001;
//    PULSES one-hot 02,04,..,80,01,02.
//  3 Latency, LANE_DEPTH=4: single 1 on D_IN at step 0, else 0
//    -> D_OUT=1 only after step 32; VALID rises after step 32.
//  4 Stall: pattern 0xA5 LSB-first with EN=0 gaps of 3 cycles every 5 steps
//    -> D_OUT reproduces 0xA5 after 32 enabled steps, no lost/duplicated bits.
//  5 Illegal state: force JOHNSON=0101 with EN=0
//    -> next edge JOHNSON=0000, PULSES=01, VALID=0, D_OUT unchanged.
//  6 LOOP_EN build: load 32-bit 0xDEADBEEF, then LOOP=1 and D_IN=0 for 64 steps
//    -> D_OUT repeats 0xDEADBEEF twice.

Source files
------------

// File: rtl/siso_hd8_if.sv
// siso_hd8_if: data and status bundle for the siso_hd8 delay line.
// The slave modport is the delay line and the master modport is its driver.
// The LOOP input exists only when SISO_HD8_LOOP_EN is defined.
interface siso_hd8_if;
  logic       en_i;
  logic       d_in_i;
`ifdef SISO_HD8_LOOP_EN
  logic       loop_i;
`endif
  logic       d_out_o;
  logic [3:0] johnson_o;
  logic [7:0] pulses_o;
  logic       valid_o;

`ifdef SISO_HD8_LOOP_EN
  modport slave  (input  en_i, d_in_i, loop_i,
                  output d_out_o, johnson_o, pulses_o, valid_o);
  modport master (output en_i, d_in_i, loop_i,
                  input  d_out_o, johnson_o, pulses_o, valid_o);
`else
  modport slave  (input  en_i, d_in_i,
                  output d_out_o, johnson_o, pulses_o, valid_o);
  modport master (output en_i, d_in_i,
                  input  d_out_o, johnson_o, pulses_o, valid_o);
`endif
endinterface

// File: rtl/siso_hd8.sv
// siso_hd8: high-density serial-in/serial-out delay line.
// Storage is split into 8 lanes of LANE_DEPTH bits. A Johnson phase counter
// selects one lane per enabled step, so the total delay is 8*LANE_DEPTH
// enabled steps.
// Optional build macro: SISO_HD8_LOOP_EN. When it is defined, the design
// adds loop_i, which recirculates each lane's shifted-out bit back into the
// same lane.
//
// phase | johnson | meaning
//   0   |  0000   | lane 0 shifts on the next enabled step
//   1   |  0001   | lane 1 shifts
//   2   |  0011   | lane 2 shifts
//   3   |  0111   | lane 3 shifts
//   4   |  1111   | lane 4 shifts
//   5   |  1110   | lane 5 shifts
//   6   |  1100   | lane 6 shifts
//   7   |  1000   | lane 7 shifts
//  --   |  other  | upset code; the next edge forces phase 0 and clears fill
module siso_hd8 #(
  parameter int LANE_DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  siso_hd8_if.slave bus
);

  localparam int TOTAL = 8 * LANE_DEPTH;
  localparam int FW    = $clog2(TOTAL + 1);

  localparam logic [3:0] PH0 = 4'b0000;
  localparam logic [3:0] PH1 = 4'b0001;
  localparam logic [3:0] PH2 = 4'b0011;
  localparam logic [3:0] PH3 = 4'b0111;
  localparam logic [3:0] PH4 = 4'b1111;
  localparam logic [3:0] PH5 = 4'b1110;
  localparam logic [3:0] PH6 = 4'b1100;
  localparam logic [3:0] PH7 = 4'b1000;

  logic [3:0]            johnson_q, johnson_d;
  logic [7:0]            pulses_q, pulses_d;
  logic [LANE_DEPTH-1:0] lane_q [8];
  logic                  d_out_q;
  logic [FW-1:0]         fill_q;
  logic                  valid_q;

  logic [2:0]            phase;
  logic                  legal;
  logic [LANE_DEPTH-1:0] lane_cur;
  logic [LANE_DEPTH-1:0] lane_shift;
  logic                  lane_in;

  // Decode the phase index and legality of the current Johnson code.
  always_comb begin
    phase = 3'd0;
    legal = 1'b1;
    case (johnson_q)
      PH0:     phase = 3'd0;
      PH1:     phase = 3'd1;
      PH2:     phase = 3'd2;
      PH3:     phase = 3'd3;
      PH4:     phase = 3'd4;
      PH5:     phase = 3'd5;
      PH6:     phase = 3'd6;
      PH7:     phase = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // Compute the next phase, its one-hot decode, and the shifted selected lane.
  always_comb begin
    johnson_d = {johnson_q[2:0], ~johnson_q[3]};
    pulses_d  = 8'b0000_0001 << (phase + 3'd1);
    lane_cur  = lane_q[phase];
`ifdef SISO_HD8_LOOP_EN
    lane_in   = bus.loop_i ? lane_cur[LANE_DEPTH-1] : bus.d_in_i;
`else
    lane_in   = bus.d_in_i;
`endif
    // The cast keeps the low LANE_DEPTH bits, which also works for a depth of 1.
    lane_shift = LANE_DEPTH'({lane_cur, lane_in});
  end

  // Phase counter, pulse decode, fill counter and valid flag.
  always_ff @(posedge clk_i) begin
    if (rst_i || !legal) begin
      johnson_q <= PH0;
      pulses_q  <= 8'b0000_0001;
      fill_q    <= '0;
      valid_q   <= 1'b0;
    end else if (bus.en_i) begin
      johnson_q <= johnson_d;
      pulses_q  <= pulses_d;
      if (fill_q != FW'(TOTAL)) begin
        fill_q <= fill_q + FW'(1);
      end
      // d_out first carries real data on the step after fill saturates.
      if (fill_q == FW'(TOTAL)) begin
        valid_q <= 1'b1;
      end
    end
  end

  // Lane storage and the output bit.
  // An upset Johnson code leaves both untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 8; k++) begin
        lane_q[k] <= '0;
      end
      d_out_q <= 1'b0;
    end else if (legal && bus.en_i) begin
      lane_q[phase] <= lane_shift;
      d_out_q       <= lane_cur[LANE_DEPTH-1];
    end
  end

  assign bus.d_out_o   = d_out_q;
  assign bus.johnson_o = johnson_q;
  assign bus.pulses_o  = pulses_q;
  assign bus.valid_o   = valid_q;

endmodule

// File: tb/tb_siso_hd8.sv
// tb_siso_hd8: directed bench for siso_hd8 with LANE_DEPTH = 4.
// The bench drives inputs and samples outputs 1 time unit after each rising edge.
module tb_siso_hd8;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  siso_hd8_if bus();

  siso_hd8 #(.LANE_DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0]  jtab [9];
  logic [7:0]  ptab [9];
  logic [7:0]  pat;
  logic [7:0]  got8;
  logic        exp_last;
  logic [31:0] word;
  logic [63:0] got64;
  int          en_cnt;
  int          gap;

  initial begin
    jtab = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
    ptab = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    pat  = 8'hA5;
    word = 32'hDEADBEEF;

    rst = 1'b1;
    bus.en_i   = 1'b0;
    bus.d_in_i = 1'b0;
`ifdef SISO_HD8_LOOP_EN
    bus.loop_i = 1'b0;
`endif
    tick();
    chk("rst_johnson", bus.johnson_o, 4'h0);
    chk("rst_pulses",  bus.pulses_o,  8'h01);
    chk("rst_dout",    bus.d_out_o,   1'b0);
    chk("rst_valid",   bus.valid_o,   1'b0);

    // Phase walk over 9 steps.
    rst = 1'b0;
    bus.en_i = 1'b1;
    bus.d_in_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("walk_johnson", bus.johnson_o, jtab[i]);
      chk("walk_pulses",  bus.pulses_o,  ptab[i]);
    end

    // Reset in the middle of a run, with EN high.
    rst = 1'b1;
    tick();
    chk("midrst_johnson", bus.johnson_o, 4'h0);
    chk("midrst_pulses",  bus.pulses_o,  8'h01);
    chk("midrst_dout",    bus.d_out_o,   1'b0);
    chk("midrst_valid",   bus.valid_o,   1'b0);

    // Latency: a single 1 at step 0 leaves d_out only after step 32.
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bus.en_i   = 1'b1;
      bus.d_in_i = (n == 0);
      tick();
      chk("lat_dout",  bus.d_out_o, (n == 32) ? 1'b1 : 1'b0);
      chk("lat_valid", bus.valid_o, (n >= 32) ? 1'b1 : 1'b0);
    end

    // Stall: send 0xA5 LSB-first, with 3 idle cycles after every 5 steps.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_cnt = 0;
    gap = 0;
    got8 = 8'h00;
    exp_last = 1'b0;
    while (en_cnt < 40) begin
      if (en_cnt > 0 && en_cnt % 5 == 0 && gap < 3) begin
        bus.en_i = 1'b0;
        bus.d_in_i = 1'b1;
        gap++;
        tick();
        chk("stall_hold", bus.d_out_o, exp_last);
      end else begin
        gap = 0;
        bus.en_i = 1'b1;
        bus.d_in_i = (en_cnt < 8) ? pat[en_cnt] : 1'b0;
        tick();
        exp_last = (en_cnt >= 32) ? pat[en_cnt-32] : 1'b0;
        if (en_cnt >= 32) got8[en_cnt-32] = bus.d_out_o;
        chk("stall_dout", bus.d_out_o, exp_last);
        en_cnt++;
      end
    end
    chk("stall_byte",  got8,        8'hA5);
    chk("stall_valid", bus.valid_o, 1'b1);

    // Upset Johnson code with EN low.
    bus.en_i = 1'b0;
    force dut.johnson_q = 4'b0101;
    #1;
    release dut.johnson_q;
    tick();
    chk("illegal_johnson", bus.johnson_o, 4'h0);
    chk("illegal_pulses",  bus.pulses_o,  8'h01);
    chk("illegal_valid",   bus.valid_o,   1'b0);
    chk("illegal_dout",    bus.d_out_o,   1'b1);
    bus.en_i = 1'b1;
    bus.d_in_i = 1'b0;
    tick();
    chk("recover_johnson", bus.johnson_o, 4'h1);
    chk("recover_valid",   bus.valid_o,   1'b0);
    bus.en_i = 1'b0;

`ifdef SISO_HD8_LOOP_EN
    // Loop: load 0xDEADBEEF, then recirculate it for 64 steps.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got64 = '0;
    for (int n = 0; n < 96; n++) begin
      bus.en_i = 1'b1;
      if (n < 32) begin
        bus.loop_i = 1'b0;
        bus.d_in_i = word[n];
      end else begin
        bus.loop_i = 1'b1;
        bus.d_in_i = 1'b0;
      end
      tick();
      if (n >= 32) got64[n-32] = bus.d_out_o;
    end
    chk("loop_first",  got64[31:0],  32'hDEADBEEF);
    chk("loop_second", got64[63:32], 32'hDEADBEEF);
    chk("loop_valid",  bus.valid_o,  1'b1);
    bus.loop_i = 1'b0;
`else
    got64 = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
